// File: rtl/branch_recovery_ctrl.sv
// Branch/JALR misprediction recovery sequencer: flush, checkpoint
// restore and fetch redirect, with dispatch stalled throughout.
module branch_recovery_ctrl #(
  parameter int ROB_BITS = 4,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mispredict_in,
  input  logic [31:0]         mispredict_target,
  input  logic [ROB_BITS-1:0] mispredict_rob_tag,
  input  logic [ROB_BITS-1:0] rob_head_tag,
  input  logic                ext_flush,
  output logic                flush_out,
  output logic [ROB_BITS-1:0] flush_rob_tag,
  output logic                ckpt_restore_req,
  output logic [ROB_BITS-1:0] ckpt_restore_tag,
  input  logic                ckpt_restore_done,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc,
  input  logic                redirect_ready,
  output logic                dispatch_stall,
  output logic                busy,
  output logic [CNT_BITS-1:0] recovery_count
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    RESTORE,
    REDIRECT
  } state_e;

  state_e              state_q, state_d;
  logic [ROB_BITS-1:0] tag_q, tag_d;
  logic [31:0]         tgt_q, tgt_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                flush_q;
  logic                req_q;
  logic                rdv_q;
  logic                busy_q;
  logic [ROB_BITS-1:0] ftag_q;
  logic [ROB_BITS-1:0] rtag_q;
  logic [31:0]         pc_q;

  logic [ROB_BITS-1:0] new_age;
  logic [ROB_BITS-1:0] cur_age;
  logic                new_older;
  logic                cnt_max;

  // Ages are relative to the ROB head so tag wrap-around is harmless
  assign new_age   = mispredict_rob_tag - rob_head_tag;
  assign cur_age   = tag_q - rob_head_tag;
  assign new_older = new_age < cur_age;
  assign cnt_max   = &cnt_q;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (ext_flush) begin
      state_d = IDLE;
    end else if (mispredict_in &&
                 (state_q == IDLE || new_older)) begin
      state_d = FLUSH;
      tag_d   = mispredict_rob_tag;
      tgt_d   = mispredict_target;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        FLUSH: state_d = RESTORE;
        RESTORE: begin
          if (ckpt_restore_done) state_d = REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state_d = IDLE;
            if (!cnt_max) cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tag_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      ftag_q  <= '0;
      rtag_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      flush_q <= (state_d == FLUSH);
      req_q   <= (state_d == RESTORE);
      rdv_q   <= (state_d == REDIRECT);
      busy_q  <= (state_d != IDLE);
      ftag_q  <= (state_d == FLUSH) ? tag_d : '0;
      rtag_q  <= (state_d == RESTORE) ? tag_d : '0;
      pc_q    <= (state_d == REDIRECT) ? tgt_d : '0;
    end
  end

  assign flush_out        = flush_q;
  assign flush_rob_tag    = ftag_q;
  assign ckpt_restore_req = req_q;
  assign ckpt_restore_tag = rtag_q;
  assign redirect_valid   = rdv_q;
  assign redirect_pc      = pc_q;
  assign dispatch_stall   = busy_q;
  assign busy             = busy_q;
  assign recovery_count   = cnt_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl (CNT_BITS=2 to reach saturation).
module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mp;
  logic [31:0] mp_tgt;
  logic [3:0]  mp_tag;
  logic [3:0]  head;
  logic        ext;
  logic        flush;
  logic [3:0]  ftag;
  logic        req;
  logic [3:0]  rtag;
  logic        done;
  logic        rdv;
  logic [31:0] pc;
  logic        ready;
  logic        stall;
  logic        busy;
  logic [1:0]  cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  branch_recovery_ctrl #(.ROB_BITS(4), .CNT_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .mispredict_in(mp),
    .mispredict_target(mp_tgt),
    .mispredict_rob_tag(mp_tag),
    .rob_head_tag(head),
    .ext_flush(ext),
    .flush_out(flush),
    .flush_rob_tag(ftag),
    .ckpt_restore_req(req),
    .ckpt_restore_tag(rtag),
    .ckpt_restore_done(done),
    .redirect_valid(rdv),
    .redirect_pc(pc),
    .redirect_ready(ready),
    .dispatch_stall(stall),
    .busy(busy),
    .recovery_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic bump();
    if (exp_cnt < 3) exp_cnt++;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"},  32'(busy), 0);
    chk({name, "_stall"}, 32'(stall), 0);
    chk({name, "_flush"}, 32'(flush), 0);
    chk({name, "_req"},   32'(req), 0);
    chk({name, "_rdv"},   32'(rdv), 0);
    chk({name, "_pc"},    pc, 0);
    chk({name, "_ftag"},  32'(ftag), 0);
    chk({name, "_rtag"},  32'(rtag), 0);
    chk({name, "_cnt"},   32'(cnt), 32'(exp_cnt));
  endtask

  task automatic fire(input logic [3:0] t, input logic [31:0] a);
    mp = 1'b1; mp_tag = t; mp_tgt = a;
    tick();
    mp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mp = 0; mp_tgt = 0; mp_tag = 0; head = 0;
    ext = 0; done = 0; ready = 0;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");

    // basic, done/ready high
    done = 1; ready = 1;
    fire(4'd3, 32'h100);
    chk("b_flush", 32'(flush), 1);
    chk("b_ftag", 32'(ftag), 3);
    chk("b_stall", 32'(stall), 1);
    chk("b_req0", 32'(req), 0);
    tick();
    chk("b_flush_off", 32'(flush), 0);
    chk("b_req", 32'(req), 1);
    chk("b_rtag", 32'(rtag), 3);
    tick();
    chk("b_req_off", 32'(req), 0);
    chk("b_rdv", 32'(rdv), 1);
    chk("b_pc", pc, 32'h100);
    tick();
    bump();
    chk_idle("b_end");

    // backpressure
    done = 0; ready = 0;
    fire(4'd5, 32'h100);
    chk("bp_flush", 32'(flush), 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_req", 32'(req), 1);
      chk("bp_rtag", 32'(rtag), 5);
      chk("bp_noflush", 32'(flush), 0);
      chk("bp_stall", 32'(stall), 1);
      if (i == 2) done = 1;
      tick();
    end
    done = 0;
    for (int i = 0; i < 2; i++) begin
      chk("bp_rdv", 32'(rdv), 1);
      chk("bp_pc", pc, 32'h100);
      chk("bp_req_off", 32'(req), 0);
      chk("bp_stall2", 32'(stall), 1);
      chk("bp_noflush2", 32'(flush), 0);
      if (i == 1) ready = 1;
      tick();
    end
    ready = 0;
    bump();
    chk_idle("bp_end");

    // older mispredict overrides across tag wrap
    head = 4'd14;
    fire(4'd1, 32'h100);
    tick();
    chk("ov_req", 32'(req), 1);
    chk("ov_rtag", 32'(rtag), 1);
    fire(4'd15, 32'h200);
    chk("ov_flush", 32'(flush), 1);
    chk("ov_ftag", 32'(ftag), 15);
    chk("ov_req_drop", 32'(req), 0);
    done = 1; ready = 1;
    tick();
    chk("ov_rtag2", 32'(rtag), 15);
    tick();
    chk("ov_pc", pc, 32'h200);
    tick();
    bump();
    chk_idle("ov_end");

    // younger mispredict ignored
    done = 0;
    fire(4'd1, 32'h100);
    tick();
    fire(4'd2, 32'h300);
    chk("yg_noflush", 32'(flush), 0);
    chk("yg_req", 32'(req), 1);
    chk("yg_rtag", 32'(rtag), 1);
    done = 1;
    tick();
    chk("yg_pc", pc, 32'h100);
    tick();
    bump();
    chk_idle("yg_end");

    // ext_flush in REDIRECT with ready low
    head = 0; ready = 0;
    fire(4'd3, 32'h40);
    tick(); tick();
    chk("ef_rdv", 32'(rdv), 1);
    ext = 1;
    tick();
    ext = 0;
    chk_idle("ef_redir");
    ext = 1; mp = 1; mp_tag = 4'd2; mp_tgt = 32'h80;
    tick();
    ext = 0; mp = 0;
    chk_idle("ef_idle");

    // reset during RESTORE
    done = 0;
    fire(4'd6, 32'h500);
    tick();
    chk("rs_req", 32'(req), 1);
    rst = 1;
    tick();
    rst = 0;
    exp_cnt = 0;
    chk_idle("rs_end");

    // counter saturation
    done = 1; ready = 1;
    for (int i = 0; i < 5; i++) begin
      fire(4'd4, 32'h600);
      tick(); tick(); tick();
      chk("sat_busy", 32'(busy), 0);
      chk("sat_cnt", 32'(cnt), 32'(sat_exp[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
